// File: rtl/csa_resolve_acc_pkg.sv
// Shared definitions for the carry-save accumulator: FSM state encoding
// and default widths.
package csa_resolve_acc_pkg;

    typedef enum logic [1:0] {
        ST_ACC     = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_HOLD    = 2'd2
    } acc_state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_ACC_W = 8;

endpackage

// File: rtl/csa_resolve_acc_csa_row.sv
// One row of per-bit full adders (3:2 compressor).
// The carry vector is returned unshifted; the caller aligns it.
module csa_row #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] s_o,
    output logic [W-1:0] cy_o
);

    assign s_o  = a_i ^ b_i ^ c_i;
    assign cy_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/csa_resolve_acc.sv
// Streaming multi-operand accumulator kept in carry-save form, resolved to
// binary by repeated carry-save passes after the last beat.
module csa_resolve_acc
    import csa_resolve_acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_sum_o,
    output logic             out_ovf_o
);

    acc_state_e       state_q;
    logic [ACC_W-1:0] s_q, c_q;
    logic             ovf_q;
    logic [ACC_W-1:0] out_sum_q;
    logic             out_ovf_q;
    logic             out_valid_q;

    logic [ACC_W-1:0] row_x, row_s, row_cy;
    logic [ACC_W-1:0] s_d, c_d;
    logic             ovf_d;

    // In RESOLVE the third row input is zero, so the row degenerates to a
    // half-adder pass: S^C and S&C.
    assign row_x = (state_q == ST_ACC) ? ACC_W'(in_data_i) : '0;

    csa_row #(.W(ACC_W)) u_row (
        .a_i  (s_q),
        .b_i  (c_q),
        .c_i  (row_x),
        .s_o  (row_s),
        .cy_o (row_cy)
    );

    assign s_d   = row_s;
    assign c_d   = {row_cy[ACC_W-2:0], 1'b0};
    assign ovf_d = ovf_q | row_cy[ACC_W-1];

    assign in_ready_o  = (state_q == ST_ACC);
    assign out_valid_o = out_valid_q;
    assign out_sum_o   = out_sum_q;
    assign out_ovf_o   = out_ovf_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_ACC;
            s_q         <= '0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid_i) begin
                        s_q   <= s_d;
                        c_q   <= c_d;
                        ovf_q <= ovf_d;
                        if (in_last_i) begin
                            state_q <= ST_RESOLVE;
                        end
                    end
                end
                ST_RESOLVE: begin
                    if (c_q == '0) begin
                        out_sum_q   <= s_q;
                        out_ovf_q   <= ovf_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else begin
                        s_q   <= s_d;
                        c_q   <= c_d;
                        ovf_q <= ovf_d;
                    end
                end
                ST_HOLD: begin
                    // Result registers keep their last value after the handshake.
                    if (out_ready_i) begin
                        s_q         <= '0;
                        c_q         <= '0;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        state_q     <= ST_ACC;
                    end
                end
                default: begin
                    state_q <= ST_ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_resolve_acc.sv
// Directed self-checking bench for csa_resolve_acc with hand-computed results.
module tb_csa_resolve_acc;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       in_valid_i;
    logic [3:0] in_data_i;
    logic       in_last_i;
    logic       in_ready_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] out_sum_o;
    logic       out_ovf_o;

    int nPass  = 0;
    int nTotal = 0;

    csa_resolve_acc #(.WIDTH(4), .ACC_W(8)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_sum_o   (out_sum_o),
        .out_ovf_o   (out_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one beat, waiting (bounded) for the block to be in ACC first.
    task automatic send_beat(input logic [3:0] v, input logic last);
        int w = 0;
        while (!in_ready_o && w < 30) begin
            @(posedge clk_i); #1;
            w++;
        end
        in_valid_i = 1'b1;
        in_data_i  = v;
        in_last_i  = last;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    // Count edges after the last beat until out_valid rises (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        nTotal++; if (out_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", out_valid_o); else nPass++;
        nTotal++; if (out_sum_o !== 8'd0) $display("[TB] FAIL reset_sum: got %0d expected 0", out_sum_o); else nPass++;
        nTotal++; if (out_ovf_o !== 1'b0) $display("[TB] FAIL reset_ovf: got %b expected 0", out_ovf_o); else nPass++;
        nTotal++; if (in_ready_o !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", in_ready_o); else nPass++;
    endtask

    task automatic test_basic_stream();
        int lat;
        int nValid;
        out_ready_i = 1'b1;
        send_beat(4'd3, 1'b0);
        send_beat(4'd5, 1'b0);
        send_beat(4'd7, 1'b1);
        nTotal++; if (in_ready_o !== 1'b0) $display("[TB] FAIL resolve_ready: got %b expected 0", in_ready_o); else nPass++;
        wait_valid(lat);
        nTotal++; if (out_valid_o !== 1'b1) $display("[TB] FAIL s357_valid: got %b expected 1 (timeout)", out_valid_o); else nPass++;
        nTotal++; if (out_sum_o !== 8'd15) $display("[TB] FAIL s357_sum: got %0d expected 15", out_sum_o); else nPass++;
        nTotal++; if (out_ovf_o !== 1'b0) $display("[TB] FAIL s357_ovf: got %b expected 0", out_ovf_o); else nPass++;
        nValid = 1;
        repeat (8) begin
            @(posedge clk_i); #1;
            if (out_valid_o) nValid++;
        end
        nTotal++; if (nValid != 1) $display("[TB] FAIL s357_once: got %0d valid cycles expected 1", nValid); else nPass++;
        nTotal++; if (out_sum_o !== 8'd15) $display("[TB] FAIL s357_keep: got %0d expected 15", out_sum_o); else nPass++;
    endtask

    task automatic test_single_beat();
        int lat;
        out_ready_i = 1'b1;
        send_beat(4'd15, 1'b1);
        wait_valid(lat);
        nTotal++; if (lat != 1 || out_valid_o !== 1'b1) $display("[TB] FAIL single_latency: got %0d expected 1", lat); else nPass++;
        nTotal++; if (out_sum_o !== 8'd15) $display("[TB] FAIL single_sum: got %0d expected 15", out_sum_o); else nPass++;
        nTotal++; if (out_ovf_o !== 1'b0) $display("[TB] FAIL single_ovf: got %b expected 0", out_ovf_o); else nPass++;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic test_overflow();
        int lat;
        out_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_beat(4'd15, (i == 19));
        end
        wait_valid(lat);
        nTotal++; if (out_valid_o !== 1'b1) $display("[TB] FAIL ovf_valid: got %b expected 1 (timeout)", out_valid_o); else nPass++;
        nTotal++; if (out_sum_o !== 8'd44) $display("[TB] FAIL ovf_sum: got %0d expected 44", out_sum_o); else nPass++;
        nTotal++; if (out_ovf_o !== 1'b1) $display("[TB] FAIL ovf_flag: got %b expected 1", out_ovf_o); else nPass++;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic test_hold_backpressure();
        int lat;
        out_ready_i = 1'b0;
        send_beat(4'd1, 1'b0);
        send_beat(4'd2, 1'b0);
        send_beat(4'd3, 1'b1);
        wait_valid(lat);
        nTotal++; if (out_valid_o !== 1'b1) $display("[TB] FAIL hold_valid: got %b expected 1 (timeout)", out_valid_o); else nPass++;
        in_valid_i = 1'b1;
        in_data_i  = 4'd9;
        in_last_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            nTotal++; if (out_valid_o !== 1'b1) $display("[TB] FAIL hold_valid_c%0d: got %b expected 1", i, out_valid_o); else nPass++;
            nTotal++; if (out_sum_o !== 8'd6) $display("[TB] FAIL hold_sum_c%0d: got %0d expected 6", i, out_sum_o); else nPass++;
            nTotal++; if (in_ready_o !== 1'b0) $display("[TB] FAIL hold_ready_c%0d: got %b expected 0", i, in_ready_o); else nPass++;
        end
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        nTotal++; if (out_valid_o !== 1'b0) $display("[TB] FAIL hold_release: got %b expected 0", out_valid_o); else nPass++;
        nTotal++; if (in_ready_o !== 1'b1) $display("[TB] FAIL hold_ready_after: got %b expected 1", in_ready_o); else nPass++;
        nTotal++; if (out_sum_o !== 8'd6) $display("[TB] FAIL hold_sum_kept: got %0d expected 6", out_sum_o); else nPass++;
        send_beat(4'd1, 1'b0);
        send_beat(4'd2, 1'b1);
        wait_valid(lat);
        nTotal++; if (out_sum_o !== 8'd3 || out_valid_o !== 1'b1) $display("[TB] FAIL hold_next_sum: got %0d expected 3", out_sum_o); else nPass++;
        nTotal++; if (out_ovf_o !== 1'b0) $display("[TB] FAIL hold_next_ovf: got %b expected 0", out_ovf_o); else nPass++;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset_in_resolve();
        int lat;
        out_ready_i = 1'b1;
        send_beat(4'd15, 1'b0);
        send_beat(4'd15, 1'b1);
        rst_n_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        nTotal++; if (out_valid_o !== 1'b0) $display("[TB] FAIL rstres_valid: got %b expected 0", out_valid_o); else nPass++;
        nTotal++; if (in_ready_o !== 1'b1) $display("[TB] FAIL rstres_ready: got %b expected 1", in_ready_o); else nPass++;
        nTotal++; if (out_sum_o !== 8'd0) $display("[TB] FAIL rstres_sum: got %0d expected 0", out_sum_o); else nPass++;
        send_beat(4'd1, 1'b0);
        send_beat(4'd2, 1'b1);
        wait_valid(lat);
        nTotal++; if (out_sum_o !== 8'd3 || out_valid_o !== 1'b1) $display("[TB] FAIL rstres_next_sum: got %0d expected 3", out_sum_o); else nPass++;
        nTotal++; if (out_ovf_o !== 1'b0) $display("[TB] FAIL rstres_next_ovf: got %b expected 0", out_ovf_o); else nPass++;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_single_beat();
        test_overflow();
        test_hold_backpressure();
        test_reset_in_resolve();
        $display("[TB] %0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/csa_resolve_acc.md
# csa_resolve_acc

Sequential multi-operand accumulator that consumes a stream of unsigned operands and holds the running total in carry-save form (sum vector S, carry vector C). One 3:2 compressor row per accepted beat keeps the per-beat path free of carry propagation. On the last beat it resolves S+C to binary by iterative carry-save passes and presents the result on a valid/ready output. It sits downstream of operand producers and replaces wide ripple adders in accumulation datapaths.

## Interface
- WIDTH, 4, operand width
- ACC_W, 8, accumulator/result width (ACC_W ≥ WIDTH)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand beat present
- in_data  in  WIDTH  unsigned operand, zero-extended to ACC_W
- in_last  in  1  marks final beat of a stream
- in_ready  out  1  block accepts a beat this cycle
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_sum  out  ACC_W  total mod 2^ACC_W
- out_ovf  out  1  true total ≥ 2^ACC_W

## Operation
- States: ACC, RESOLVE, HOLD. Reset → ACC; S=C=0, ovf sticky=0, out_valid=0, out_sum=0, out_ovf=0.
- in_ready = (state==ACC), combinational from state only.
- ACC, beat accepted (in_valid & in_ready): S ← S^C^x; C ← (maj(S,C,x) << 1) truncated to ACC_W; bit shifted out of maj MSB ORs into ovf. in_last=1 → RESOLVE next cycle.
- RESOLVE, each cycle: if C==0 → out_sum ← S, out_ovf ← ovf, out_valid ← 1, state HOLD. Else S ← S^C, C ← (S&C)<<1 truncated, MSB of (S&C) ORs into ovf.
- HOLD: outputs stable while out_valid & !out_ready. On out_valid & out_ready: S, C, ovf cleared, out_valid ← 0, state ACC. out_sum/out_ovf keep last values after handshake.
- in_valid outside ACC ignored (no state change, no overflow effect).
- Arithmetic unsigned, modulo 2^ACC_W. ovf is exact: set iff sum of stream ≥ 2^ACC_W.
- Reset mid-stream/mid-RESOLVE/mid-HOLD: partial result discarded, all state as reset.

## Timing
- Per-beat throughput: 1 beat/cycle in ACC.
- Last beat accepted at edge T: state RESOLVE after T; out_valid high after edge T+k, k = RESOLVE passes + 1, 1 ≤ k ≤ ACC_W+1.
- C==0 at RESOLVE entry → out_valid after edge T+1 (minimum latency 1).
- Handshake at edge H → in_ready high after H; earliest next beat accepted at edge H+1.
- No combinational path from inputs to outputs; in_ready depends on state only.

## Structure
- Shared package: state encoding constants (ACC, RESOLVE, HOLD), default WIDTH/ACC_W.
- Sub-module csa_row: ACC_W-wide 3:2 compressor (per-bit full adders, inputs a,b,c, outputs s, carry vector unshifted); used for both accumulate and resolve (third input 0 in RESOLVE).
- Top: FSM, S/C/ovf registers, output registers.

## Test plan
- Reset held 3 cycles then released → out_valid=0, out_sum=0, out_ovf=0, in_ready=1.
- Beats 3,5,7 (in_last on 7), out_ready=1 → out_sum=15, out_ovf=0, one result only.
- Single beat 15 with in_last → out_valid after edge T+1, out_sum=15, out_ovf=0.
- 20 beats of 15, last on 20th → out_sum=44 (300 mod 256), out_ovf=1.
- out_ready low 5 cycles in HOLD with in_valid=1, in_data=9 → out_sum stable, in_ready=0, beats ignored; next stream 1,2 → 3.
- rst_n low 1 cycle during RESOLVE → out_valid=0, state ACC; then stream 1,2 last → out_sum=3, out_ovf=0.
